// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and helpers for the multi-word add/sub sequencer.
// Contents:
//   state_e          - sequencer FSM states
//   DefWordW         - default adder slice width
//   DefNumWords      - default number of slices per operand
//   signed_overflow  - two's-complement overflow from the operand/result sign bits
package multiword_add_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefWordW    = 8;
  localparam int unsigned DefNumWords = 4;

  // b_msb is the sign of the operand as actually fed to the adder (already inverted for sub),
  // so the same expression covers both add and subtract.
  function automatic logic signed_overflow(input logic a_msb, input logic b_msb,
                                           input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// Handshake bundle between operand producer / result consumer and the sequencer.
// Signals:
//   start_valid, start_ready - operand-side handshake
//   op_a, op_b, sub, cin     - operands and mode, sampled on the accepting edge
//   res_valid, res_ready     - result-side handshake
//   result, cout, overflow   - result word, final carry and signed overflow
//   busy                     - sequencer is in RUN or DONE
// Modports: master = producer/consumer side, slave = sequencer side.
interface multiword_add_sequencer_if #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned NUM_WORDS = 4
);
  localparam int unsigned W = WORD_W * NUM_WORDS;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         cin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         busy;

  modport master (
    output start_valid, op_a, op_b, sub, cin, res_ready,
    input  start_ready, res_valid, result, cout, overflow, busy
  );

  modport slave (
    input  start_valid, op_a, op_b, sub, cin, res_ready,
    output start_ready, res_valid, result, cout, overflow, busy
  );

endinterface

// File: rtl/multiword_add_sequencer_word_adder.sv
// Combinational WORD_W-bit ripple-carry adder slice, shared across all words.
// Ports:
//   a, b - slice operands
//   ci   - carry in
//   s    - slice sum
//   co   - carry out of the slice MSB
module word_adder #(
  parameter int unsigned WORD_W = 8
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              ci,
  output logic [WORD_W-1:0] s,
  output logic              co
);

  logic c;

  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < int'(WORD_W); i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract built by time-sharing one WORD_W-bit adder slice, LS word first,
// one word per clock, with the inter-word carry held in a flop.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of multiword_add_sequencer_if (handshakes, operands, results)
// Timing: res_valid rises NUM_WORDS cycles after the accepting edge; the result is held
// until res_ready, then one IDLE cycle precedes the next accept.
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int unsigned WORD_W    = DefWordW,
  parameter int unsigned NUM_WORDS = DefNumWords
) (
  input  logic                          clk,
  input  logic                          rst_n,
  multiword_add_sequencer_if.slave      bus
);

  localparam int unsigned W    = WORD_W * NUM_WORDS;
  localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);

  state_e          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic [IdxW-1:0] idx_q;
  logic            carry_q;
  logic            cout_q;
  logic            overflow_q;
  logic            start_ready_q;
  logic            res_valid_q;
  logic            busy_q;

  logic [WORD_W-1:0] slice_a;
  logic [WORD_W-1:0] slice_b;
  logic [WORD_W-1:0] slice_s;
  logic              slice_co;

  assign slice_a = a_q[idx_q*WORD_W +: WORD_W];
  assign slice_b = b_q[idx_q*WORD_W +: WORD_W];

  word_adder #(
    .WORD_W (WORD_W)
  ) u_word_adder (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      a_q           <= '0;
      b_q           <= '0;
      result_q      <= '0;
      idx_q         <= '0;
      carry_q       <= 1'b0;
      cout_q        <= 1'b0;
      overflow_q    <= 1'b0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.start_valid) begin
            a_q           <= bus.op_a;
            // Subtract as A + ~B + 1, so the slice never needs to know the mode.
            b_q           <= bus.sub ? ~bus.op_b : bus.op_b;
            carry_q       <= bus.sub ? 1'b1 : bus.cin;
            idx_q         <= '0;
            result_q      <= '0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state         <= StRun;
          end
        end
        StRun: begin
          result_q[idx_q*WORD_W +: WORD_W] <= slice_s;
          carry_q <= slice_co;
          if (idx_q == LastIdx) begin
            cout_q      <= slice_co;
            overflow_q  <= signed_overflow(a_q[W-1], b_q[W-1], slice_s[WORD_W-1]);
            idx_q       <= '0;
            res_valid_q <= 1'b1;
            state       <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          // start_ready only returns in IDLE, so a start coinciding with res_ready waits.
          if (bus.res_ready) begin
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
            state         <= StIdle;
          end
        end
        default: begin
          state         <= StIdle;
          start_ready_q <= 1'b1;
          res_valid_q   <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.result      = result_q;
  assign bus.cout        = cout_q;
  assign bus.overflow    = overflow_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (WORD_W=8, NUM_WORDS=4).
module tb_multiword_add_sequencer;

  localparam int unsigned WordW    = 8;
  localparam int unsigned NumWords = 4;
  localparam int unsigned W        = WordW * NumWords;

  logic clk;
  logic rst_n;

  multiword_add_sequencer_if #(.WORD_W(WordW), .NUM_WORDS(NumWords)) bus ();

  multiword_add_sequencer #(
    .WORD_W    (WordW),
    .NUM_WORDS (NumWords)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] exp_res;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  int tests;
  int fails;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts posedges after the accepting edge until res_valid is seen (bounded).
  task automatic wait_result(output int cycles);
    cycles = 0;
    while (bus.res_valid !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // Presents operands at a negedge; returns #1 after the accepting posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic c);
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    bus.sub  = s;
    bus.cin  = c;
    check("start_ready_before_accept", 64'(bus.start_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    // Scramble inputs: only the accepting edge may sample them.
    bus.op_a = ~a;
    bus.op_b = ~b;
    bus.sub  = ~s;
    bus.cin  = ~c;
    check("busy_after_accept", 64'(bus.busy), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int cyc;
    issue(v.a, v.b, v.sub, v.cin);
    wait_result(cyc);
    check($sformatf("latency[%0d]", n), 64'(cyc), 64'(NumWords));
    check($sformatf("result[%0d]", n), 64'(bus.result), 64'(v.exp_res));
    check($sformatf("cout[%0d]", n), 64'(bus.cout), 64'(v.exp_cout));
    check($sformatf("overflow[%0d]", n), 64'(bus.overflow), 64'(v.exp_ovf));
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check($sformatf("res_valid_dropped[%0d]", n), 64'(bus.res_valid), 64'd0);
    check($sformatf("start_ready_back[%0d]", n), 64'(bus.start_ready), 64'd1);
  endtask

  vec_t vecs[9];

  initial begin
    int cyc;
    logic [W-1:0] held;
    tests = 0;
    fails = 0;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[5] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0};
    vecs[6] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0};
    vecs[7] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0};
    vecs[8] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};

    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    bus.sub         = 1'b0;
    bus.cin         = 1'b0;
    bus.res_ready   = 1'b0;
    #12;
    check("rst_start_ready", 64'(bus.start_ready), 64'd1);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // res_ready outside DONE must be ignored.
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("idle_res_ready_ignored", 64'({bus.start_ready, bus.busy}), 64'b10);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Backpressure: DONE held 3 cycles, starts ignored, then coincident start waits.
    issue(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    wait_result(cyc);
    check("bp_latency", 64'(cyc), 64'(NumWords));
    held = bus.result;
    check("bp_result", 64'(held), 64'h100);
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.op_a = 32'h00000002;
    bus.op_b = 32'h00000003;
    bus.sub  = 1'b0;
    bus.cin  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_result[%0d]", k), 64'(bus.result), 64'h100);
      check($sformatf("bp_hold_valid[%0d]", k), 64'(bus.res_valid), 64'd1);
      check($sformatf("bp_hold_start_ready[%0d]", k), 64'(bus.start_ready), 64'd0);
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("bp_release_idle", 64'({bus.start_ready, bus.res_valid, bus.busy}), 64'b100);
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    check("bp_b2b_accepted", 64'({bus.start_ready, bus.busy}), 64'b01);
    wait_result(cyc);
    check("bp_b2b_latency", 64'(cyc), 64'(NumWords));
    check("bp_b2b_result", 64'(bus.result), 64'h5);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;

    // Reset two cycles into RUN: asynchronous clear, no stale result afterwards.
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("mid_run_busy_pre", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_result", 64'(bus.result), 64'd0);
    check("async_rst_start_ready", 64'(bus.start_ready), 64'd1);
    check("async_rst_res_valid", 64'(bus.res_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_idle[%0d]", k),
            64'({bus.start_ready, bus.res_valid, bus.busy}), 64'b100);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
